// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to binary converter, one digit per clock,
// with saturation on overflow and rejection of non-decimal digits.
module bcd2bin_seq #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [4*D-1:0] bcd,
    output logic           ready,
    output logic           done,
    output logic [W-1:0]   bin,
    output logic           ovf,
    output logic           err
);
    localparam int CW = $clog2(D + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t         state, state_nx;
    logic [4*D-1:0] sr, acc, acc_nx;
    logic [CW-1:0]  cnt;
    logic           bad, last, big;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < D; i++) bad = bad | (bcd[4*i +: 4] > 4'd9);
    end

    // acc*10 as shifts keeps the sum at the accumulator width
    assign acc_nx = (acc << 3) + (acc << 1) + {{(4*D-4){1'b0}}, sr[4*D-1 -: 4]};
    assign last   = cnt == CW'(D - 1);
    assign big    = (acc_nx >> W) != '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (start ? (bad ? DONE : CONV) : IDLE) :
                   state == CONV ? (last ? DONE : CONV) : IDLE;
    end

    always_comb begin
        ready = state == IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr   <= '0;
            acc  <= '0;
            cnt  <= '0;
            bin  <= '0;
            ovf  <= 1'b0;
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= state_nx == DONE;
            if (state == IDLE && start) begin
                sr  <= bcd;
                acc <= '0;
                cnt <= '0;
                bin <= '0;
                ovf <= 1'b0;
                err <= bad;
            end else if (state == CONV) begin
                acc <= acc_nx;
                sr  <= sr << 4;
                cnt <= cnt + 1'b1;
                if (last) begin
                    ovf <= big;
                    bin <= big ? '1 : W'(acc_nx);
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: randomized and directed checks of bcd2bin_seq against an
// arithmetic reference model (W=8, D=3).
module tb_bcd2bin_seq;
    localparam int W = 8;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [4*D-1:0] bcd = '0;
    logic           ready, done, ovf, err;
    logic [W-1:0]   bin;

    int n_cmp = 0;
    int n_bad = 0;

    bcd2bin_seq #(.W(W), .D(D)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bcd(bcd),
        .ready(ready), .done(done), .bin(bin), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [4*D-1:0] v, output int eb, output bit eo, output bit ee);
        int val = 0;
        ee = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            logic [3:0] d = v[4*i +: 4];
            if (d > 9) ee = 1'b1;
            val = val * 10 + int'(d);
        end
        eo = !ee && val > (1 << W) - 1;
        eb = ee ? 0 : (eo ? (1 << W) - 1 : val);
    endfunction

    task automatic convert(input logic [4*D-1:0] v);
        int  eb, lat;
        bit  eo, ee;
        model(v, eb, eo, ee);
        @(negedge clk);
        check("ready_idle", ready, 1);
        bcd   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcd   = 12'($urandom);
        check("ready_busy", ready, 0);
        lat = 0;
        while (!done && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, ee ? 0 : D);
        check("bin", bin, eb);
        check("ovf", ovf, eo);
        check("err", err, ee);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("ready_after", ready, 1);
        check("bin_hold", bin, eb);
    endtask

    initial begin
        int ndone, prev, lastbin;
        logic [4*D-1:0] v;
        #2;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_bin", bin, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        reset_n = 1'b1;

        convert(12'h000);
        convert(12'h001);
        convert(12'h098);
        convert(12'h129);
        convert(12'h255);
        convert(12'h256);
        convert(12'h999);
        convert(12'h1A5);
        convert(12'hF00);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) v = 12'($urandom);
            else for (int j = 0; j < D; j++) v[4*j +: 4] = 4'($urandom_range(0, 9));
            convert(v);
        end

        // start pulsed during CONV must be ignored
        @(negedge clk);
        bcd = 12'h200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        bcd = 12'h050;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        lastbin = -1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                lastbin = int'(bin);
            end
        end
        check("ignore_done_cnt", ndone, 1);
        check("ignore_bin", lastbin, 200);

        // reset mid-conversion aborts without a done pulse
        @(negedge clk);
        bcd = 12'h150;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_bin", bin, 0);
        check("abort_done", done, 0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        @(negedge clk);
        reset_n = 1'b1;
        convert(12'h007);

        // start held high: one result every D+2 cycles
        @(negedge clk);
        bcd = 12'h123;
        start = 1'b1;
        ndone = 0;
        prev = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                check("hold_bin", bin, 123);
                if (prev >= 0) check("hold_gap", i - prev, D + 2);
                prev = i;
                ndone++;
            end
        end
        start = 1'b0;
        check("hold_count", ndone, 4);
        repeat (8) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 The block SHALL have parameter W, default 8, the binary output width.
REQ-002 The block SHALL have parameter D, default 3, the number of packed BCD input digits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request, sampled only while ready=1.
REQ-006 The block SHALL have port bcd, input, 4*D bits: packed BCD operand, most significant digit in bits [4D-1:4D-4].
REQ-007 The block SHALL have port ready, output, 1 bit: high exactly when the block is in IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have port bin, output, W bits: the binary result.
REQ-010 The block SHALL have port ovf, output, 1 bit: the decimal value exceeded 2^W-1.
REQ-011 The block SHALL have port err, output, 1 bit: an input digit was greater than 9.

Function
REQ-012 The block SHALL implement the states IDLE, CONV and DONE, and SHALL not enter any other state.
REQ-013 In IDLE with start=1 at edge k, the block SHALL capture bcd into an internal digit shift register, clear the accumulator and the digit counter, and clear bin, ovf and err.
REQ-014 At edge k, if any captured digit is greater than 9, the block SHALL go to DONE with err=1, bin=0 and ovf=0, and SHALL not enter CONV.
REQ-015 At edge k, if all digits are valid, the block SHALL go to CONV.
REQ-016 On each CONV edge, the block SHALL compute acc = acc*10 + top digit, shift the digit register left by 4, and increment the counter.
REQ-017 The accumulator SHALL be 4*D bits wide so that it never wraps, because 10^D-1 < 16^D.
REQ-018 After exactly D CONV edges, at edge k+D, the block SHALL go to DONE and load bin and ovf.
REQ-019 If acc > 2^W-1, the block SHALL load ovf=1 and saturate bin to all ones.
REQ-020 Otherwise the block SHALL load ovf=0 and bin=acc[W-1:0].
REQ-021 done SHALL be 1 for exactly the one cycle spent in DONE, and DONE SHALL always go to IDLE on the next edge.
REQ-022 Valid latency SHALL be: start edge k, done high during the cycle after edge k+D, ready high again after edge k+D+1.
REQ-023 Invalid-input latency SHALL be: done high during the cycle after edge k, ready high after edge k+1.
REQ-024 bin, ovf and err SHALL hold their values after DONE until the next accepted start.
REQ-025 start while ready=0 SHALL be ignored, and bcd changes during CONV SHALL not affect the result.
REQ-026 start held high continuously SHALL begin a new conversion on the first edge in IDLE after DONE, with no back-to-back acceptance without that IDLE cycle.
REQ-027 The block SHALL be purely sequential in its outputs: bin, ovf, err and done SHALL be registered, and ready SHALL decode state only.

Reset
REQ-028 While reset_n=0, the block SHALL force state IDLE, acc=0, counter=0, digit register=0, bin=0, ovf=0, err=0 and done=0, independent of clk.
REQ-029 Because ready decodes IDLE, ready SHALL be 1 during and after reset.
REQ-030 Reset asserted mid-CONV or in DONE SHALL abort the conversion with no done pulse, and results SHALL read 0.
REQ-031 The first start SHALL be accepted on the first rising edge with reset_n=1.

Verification (W=8, D=3)
REQ-032 bcd=12'h000, 12'h001, 12'h098 and 12'h129 -> bin=0, 1, 98 and 129 respectively, with ovf=0, err=0, and done exactly 3 cycles after the start edge.
REQ-033 bcd=12'h255 -> bin=255, ovf=0; then bcd=12'h256 -> bin=255 (saturated), ovf=1; then bcd=12'h999 -> bin=255, ovf=1.
REQ-034 bcd=12'h1A5 and 12'hF00 -> err=1, bin=0, ovf=0, done on the cycle after the start edge, never entering CONV.
REQ-035 Start 12'h200, then pulse start with bcd=12'h050 during CONV -> result bin=200, and only one done pulse occurs.
REQ-036 Start 12'h150, then assert reset_n=0 after 2 CONV edges -> no done pulse, ready=1, bin=0; after release, start 12'h007 -> bin=7.
REQ-037 start held high for 20 cycles with bcd=12'h123 -> a done pulse every 5 cycles, each with bin=123.
